busca_instrucao: RTL and testbench



---
 rtl/busca_instrucao_pkg.sv | 32 +++
 rtl/busca_instrucao_if.sv | 24 ++
 rtl/busca_instrucao_skid.sv | 51 +++++
 rtl/busca_instrucao.sv | 180 ++++++++++++++++++
 tb/tb_busca_instrucao.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, word
// widths, the decode-safe filler word and small address helpers.
package busca_instrucao_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_FETCH   = 2'd1,
        S_FULL    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  pc;
    } fetch_word_t;

    // Branch targets are word addresses; the two byte-offset bits are dropped.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [ADDR_W-1:0] step_pc(input logic [ADDR_W-1:0] pc,
                                                  input logic [ADDR_W-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface busca_instrucao_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/busca_instrucao_skid.sv
// One-entry {data, pc, valid} skid buffer that catches a fetched word while
// decode is stalled.
module busca_skid
    import busca_instrucao_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  fetch_word_t word_i,
    input  logic        drain_i,
    input  logic        flush_i,
    output logic        valid_o,
    output fetch_word_t word_o
);

    logic        valid_q;
    logic        valid_d;
    fetch_word_t word_q;
    fetch_word_t word_d;

    // Flush beats load, and load beats drain so a same-cycle drain and refill keeps the new word.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            word_d  = word_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Skid storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory and presents a registered instruction to decode.
module busca_instrucao #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'h0000_0004,
    parameter logic [31:0] NOP_WORD = busca_instrucao_pkg::NOP_WORD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    busca_instrucao_if.master        imem,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic [31:0]              instrucao_o,
    output logic [31:0]              pc_instr_o,
    output logic                     instr_valid_o
);

    import busca_instrucao_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  held_q, held_d;
    logic         req_q, req_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;

    logic         ack_s;
    logic         ack_fetch_s;
    logic         accept_s;
    logic [31:0]  target_s;
    logic         skid_load_s;
    logic         skid_drain_s;
    logic         skid_flush_s;
    logic         skid_valid_s;
    fetch_word_t  skid_word_s;
    fetch_word_t  mem_word_s;

    // An ack only counts while a request is actually on the bus.
    assign ack_s       = imem.imem_ack & req_q;
    assign ack_fetch_s = ack_s & (state_q == S_FETCH);
    assign accept_s    = ~valid_q | ~stall_i;
    assign target_s    = align_word(redirect_pc_i);
    assign mem_word_s  = '{data: imem.imem_rdata, pc: fetch_pc_q};

    busca_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load_s),
        .word_i  (mem_word_s),
        .drain_i (skid_drain_s),
        .flush_i (skid_flush_s),
        .valid_o (skid_valid_s),
        .word_o  (skid_word_s)
    );

    // Output register steering: redirect clears, then skid has priority over fresh memory data.
    always_comb begin
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        skid_load_s  = 1'b0;
        skid_drain_s = 1'b0;
        skid_flush_s = redirect_i;
        if (redirect_i) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end else begin
            if (skid_valid_s && accept_s) begin
                skid_drain_s = 1'b1;
                valid_d      = 1'b1;
                instr_d      = skid_word_s.data;
                pc_out_d     = skid_word_s.pc;
            end else if (ack_fetch_s && accept_s) begin
                valid_d  = 1'b1;
                instr_d  = imem.imem_rdata;
                pc_out_d = fetch_pc_q;
            end else if (accept_s) begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
            end else begin
                valid_d = valid_q;
            end
            skid_load_s = ack_fetch_s & ~(accept_s & ~skid_valid_s);
        end
    end

    // Fetch FSM next-state and PC update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        held_d     = held_q;
        case (state_q)
            S_RESET: begin
                if (redirect_i) begin
                    fetch_pc_d = target_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_i) begin
                    if (ack_s) begin
                        fetch_pc_d = target_s;
                        state_d    = S_FETCH;
                    end else begin
                        held_d  = target_s;
                        state_d = S_DISCARD;
                    end
                end else if (ack_s) begin
                    fetch_pc_d = step_pc(fetch_pc_q, PC_STEP);
                    state_d    = skid_load_s ? S_FULL : S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FULL: begin
                if (redirect_i) begin
                    fetch_pc_d = target_s;
                    state_d    = S_FETCH;
                end else if (accept_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FULL;
                end
            end
            S_DISCARD: begin
                // The in-flight word belongs to the abandoned stream; it completes but is dropped.
                if (redirect_i) begin
                    if (ack_s) begin
                        fetch_pc_d = target_s;
                        state_d    = S_FETCH;
                    end else begin
                        held_d  = target_s;
                        state_d = S_DISCARD;
                    end
                end else if (ack_s) begin
                    fetch_pc_d = held_q;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
        req_d = (state_d == S_FETCH) || (state_d == S_DISCARD);
    end

    // State, PC and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            fetch_pc_q <= RESET_PC;
            held_q     <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= NOP_WORD;
            pc_out_q   <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            held_q     <= held_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = fetch_pc_q;
    assign instrucao_o    = instr_q;
    assign pc_instr_o     = pc_out_q;
    assign instr_valid_o  = valid_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for the fetch stage: a zero-wait memory that answers
// rdata = addr + 0x100 whenever enabled, with hand-computed expectations.
module tb_busca_instrucao;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instrucao;
    logic [31:0] pc_instr;
    logic        instr_valid;
    bit          ack_en;
    int          vectors;
    int          errors;

    busca_instrucao_if bus ();

    busca_instrucao dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instrucao_o   (instrucao),
        .pc_instr_o    (pc_instr),
        .instr_valid_o (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_mem();
        bus.imem_ack   = ack_en && bus.imem_req;
        bus.imem_rdata = bus.imem_addr + 32'h0000_0100;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_mem();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({tag, ".instr"}, instrucao, ins);
        chk({tag, ".pc"}, pc_instr, pc);
    endtask

    task automatic chk_bus(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, r});
        chk({tag, ".addr"}, bus.imem_addr, a);
    endtask

    initial begin
        vectors        = 0;
        errors         = 0;
        ack_en         = 1'b0;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0000_0000;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0000_0000;
        tick();
        tick();
        chk_bus("reset", 1'b0, 32'h0000_0000);
        chk_out("reset", 1'b0, 32'h0000_0000, 32'h0000_0000);

        // Streaming with ack every cycle
        rst_n  = 1'b1;
        ack_en = 1'b1;
        tick();
        chk_bus("first_req", 1'b1, 32'h0000_0000);
        chk_out("first_req", 1'b0, 32'h0000_0000, 32'h0000_0000);
        tick();
        chk_out("stream0", 1'b1, 32'h0000_0100, 32'h0000_0000);
        chk_bus("stream0", 1'b1, 32'h0000_0004);
        tick();
        chk_out("stream1", 1'b1, 32'h0000_0104, 32'h0000_0004);
        chk_bus("stream1", 1'b1, 32'h0000_0008);
        tick();
        chk_out("stream2", 1'b1, 32'h0000_0108, 32'h0000_0008);
        chk_bus("stream2", 1'b1, 32'h0000_000C);

        // Stall for three cycles: word 0xC goes to the skid, requests stop
        stall = 1'b1;
        tick();
        chk_out("stall1", 1'b1, 32'h0000_0108, 32'h0000_0008);
        chk_bus("stall1", 1'b0, 32'h0000_0010);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk_out("stall2", 1'b1, 32'h0000_0108, 32'h0000_0008);
        chk_bus("stall2", 1'b0, 32'h0000_0010);
        tick();
        chk_out("stall3", 1'b1, 32'h0000_0108, 32'h0000_0008);
        stall = 1'b0;
        tick();
        chk_out("unstall_skid", 1'b1, 32'h0000_010C, 32'h0000_000C);
        chk_bus("unstall_skid", 1'b1, 32'h0000_0010);
        tick();
        chk_out("unstall_next", 1'b1, 32'h0000_0110, 32'h0000_0010);
        chk_bus("unstall_next", 1'b1, 32'h0000_0014);

        // Redirect while the request to 0x14 is pending; target low bits are masked
        ack_en      = 1'b0;
        drive_mem();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0041;
        tick();
        redirect = 1'b0;
        chk_out("redir_pend", 1'b0, 32'h0000_0000, 32'h0000_0010);
        chk_bus("redir_pend", 1'b1, 32'h0000_0014);
        tick();
        chk_bus("discard_hold", 1'b1, 32'h0000_0014);
        ack_en = 1'b1;
        drive_mem();
        tick();
        chk_out("discard_drop", 1'b0, 32'h0000_0000, 32'h0000_0010);
        chk_bus("discard_drop", 1'b1, 32'h0000_0040);
        tick();
        chk_out("after_redir", 1'b1, 32'h0000_0140, 32'h0000_0040);
        chk_bus("after_redir", 1'b1, 32'h0000_0044);

        // Redirect together with an ack while stalled (word would have hit the skid)
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        tick();
        redirect = 1'b0;
        chk_out("redir_ack_stall", 1'b0, 32'h0000_0000, 32'h0000_0040);
        chk_bus("redir_ack_stall", 1'b1, 32'h0000_0080);
        tick();
        chk_out("redir_target", 1'b1, 32'h0000_0180, 32'h0000_0080);
        tick();
        chk_out("fill_skid", 1'b1, 32'h0000_0180, 32'h0000_0080);
        chk_bus("fill_skid", 1'b0, 32'h0000_0088);

        // Redirect with the skid full and decode stalled
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        chk_out("redir_full", 1'b0, 32'h0000_0000, 32'h0000_0080);
        chk_bus("redir_full", 1'b1, 32'h0000_0200);
        tick();
        chk_out("skid_flushed", 1'b1, 32'h0000_0300, 32'h0000_0200);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk_bus("wrap_pre", 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap_word", 1'b1, 32'h0000_00FC, 32'hFFFF_FFFC);
        chk_bus("wrap_addr", 1'b1, 32'h0000_0000);
        tick();
        chk_out("wrap_next", 1'b1, 32'h0000_0100, 32'h0000_0000);

        // Asynchronous reset in the middle of a request
        #2;
        rst_n        = 1'b0;
        ack_en       = 1'b0;
        bus.imem_ack = 1'b0;
        #1;
        chk_bus("async_rst", 1'b0, 32'h0000_0000);
        chk_out("async_rst", 1'b0, 32'h0000_0000, 32'h0000_0000);
        tick();
        tick();
        rst_n  = 1'b1;
        ack_en = 1'b1;
        tick();
        chk_bus("restart", 1'b1, 32'h0000_0000);
        tick();
        chk_out("restart", 1'b1, 32'h0000_0100, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
